// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready bundle for one side of an elastic pipeline boundary.
// The producer drives valid/ctrl/data through master; the consumer drives ready through slave.
interface pipe_stage_elastic_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 133
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, ctrl, data, input ready);
  modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a main entry and a skid entry.
// The skid entry keeps in_ready a pure register output. Also provides flush and a saturating stall counter.
module pipe_stage_elastic #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 133,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 clr_cnt_i,
  pipe_stage_elastic_if.slave  up_if,
  pipe_stage_elastic_if.master dn_if,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } occ_e;

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  logic acc;
  logic dq;
  occ_e occ;

  assign occ = occ_e'({main_valid_q, skid_valid_q});
  assign acc = up_if.valid & up_if.ready;
  assign dq  = main_valid_q & dn_if.ready;

  assign up_if.ready = ~skid_valid_q;
  assign dn_if.valid = main_valid_q;
  assign dn_if.ctrl  = main_ctrl_q;
  assign dn_if.data  = main_data_q;
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    // NOTE: every _d starts as its _q, so no branch below can leave a latch behind.
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ctrl_d  = main_ctrl_q;
    skid_ctrl_d  = skid_ctrl_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
    end else begin
      case (occ)
        EMPTY: begin
          if (acc) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = up_if.ctrl;
            main_data_d  = up_if.data;
          end
        end
        FULL: begin
          if (dq && acc) begin
            main_ctrl_d = up_if.ctrl;
            main_data_d = up_if.data;
          end else if (dq) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
          end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = up_if.ctrl;
            skid_data_d  = up_if.data;
          end
        end
        SKID: begin
          if (dq) begin
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt_i) begin
      stall_cnt_d = '0;
    end else if (main_valid_q && !dn_if.ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: data registers are reset too, so out_data reads zero before the first entry arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus random traffic against a
// 2-deep FIFO reference model; a CNT_W=2 twin checks counter saturation.
module tb_pipe_stage_elastic;
  localparam int CTRL_W = 8;
  localparam int DATA_W = 133;
  localparam int W      = 160;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst, flush, clr_cnt;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  pipe_stage_elastic_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_up  ();
  pipe_stage_elastic_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_dn  ();
  pipe_stage_elastic_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_up2 ();
  pipe_stage_elastic_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_dn2 ();

  assign u_up2.valid = u_up.valid;
  assign u_up2.ctrl  = u_up.ctrl;
  assign u_up2.data  = u_up.data;
  assign u_dn2.ready = u_dn.ready;

  pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush), .clr_cnt_i(clr_cnt),
    .up_if(u_up), .dn_if(u_dn), .stall_cnt_o(stall_cnt)
  );

  pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush_i(flush), .clr_cnt_i(clr_cnt),
    .up_if(u_up2), .dn_if(u_dn2), .stall_cnt_o(stall_cnt2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the stage behaves as a 2-deep FIFO with in_ready = (occupancy < 2).
  entry_t q_m[$];
  int     stall_m  = 0;
  int     stall2_m = 0;
  logic   last_acc = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [W-1:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[DATA_W-1:0];
  endfunction

  task automatic drive_in(input logic v, input logic [CTRL_W-1:0] c);
    u_up.valid = v;
    u_up.ctrl  = c;
    u_up.data  = rand_data();
  endtask

  // One clock: compare outputs to the model mid-cycle, then advance the model at the edge.
  task automatic step();
    logic exp_ready, saved, acc, dq;
    @(negedge clk);
    exp_ready = (q_m.size() < 2);
    check("in_ready", W'(u_up.ready), W'(exp_ready));
    check("out_valid", W'(u_dn.valid), W'(q_m.size() > 0));
    check("out_ctrl", W'(u_dn.ctrl), (q_m.size() > 0) ? W'(q_m[0].ctrl) : '0);
    if (q_m.size() > 0) check("out_data", W'(u_dn.data), W'(q_m[0].data));
    check("stall_cnt", W'(stall_cnt), W'(stall_m));
    check("stall_cnt2", W'(stall_cnt2), W'(stall2_m));
    saved = u_dn.ready;
    u_dn.ready = ~saved;
    #1;
    check("in_ready_indep", W'(u_up.ready), W'(exp_ready));
    u_dn.ready = saved;
    #1;
    acc = u_up.valid && (q_m.size() < 2);
    dq  = (q_m.size() > 0) && u_dn.ready;
    @(posedge clk);
    last_acc = acc;
    if (rst) begin
      q_m.delete();
      stall_m  = 0;
      stall2_m = 0;
    end else begin
      if (clr_cnt) begin
        stall_m  = 0;
        stall2_m = 0;
      end else if (q_m.size() > 0 && !u_dn.ready) begin
        if (stall_m < 65535) stall_m++;
        if (stall2_m < 3) stall2_m++;
      end
      if (flush) begin
        q_m.delete();
      end else begin
        if (dq) void'(q_m.pop_front());
        if (acc) q_m.push_back('{ctrl: u_up.ctrl, data: u_up.data});
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clr_cnt = 1'b0;
    u_up.valid = 1'b0; u_up.ctrl = '0; u_up.data = '0;
    u_dn.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", W'(u_up.ready), W'(1));
    check("rst_out_valid", W'(u_dn.valid), W'(0));
    check("rst_out_ctrl", W'(u_dn.ctrl), W'(0));
    check("rst_out_data", W'(u_dn.data), W'(0));
    check("rst_stall", W'(stall_cnt), W'(0));

    // Streaming with downstream always ready.
    u_dn.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_in(1'b1, CTRL_W'(i + 1));
      step();
      check("s1_out_ctrl", W'(u_dn.ctrl), W'(i + 1));
      check("s1_in_ready", W'(u_up.ready), W'(1));
    end
    drive_in(1'b0, '0);
    step();
    check("s1_stall", W'(stall_cnt), W'(0));

    // Fill main, then skid while downstream stalls; drain in order.
    u_dn.ready = 1'b0;
    drive_in(1'b1, 8'h5A);
    step();
    drive_in(1'b1, 8'h3C);
    step();
    drive_in(1'b0, '0);
    check("s2_in_ready_low", W'(u_up.ready), W'(0));
    check("s2_head", W'(u_dn.ctrl), W'(8'h5A));
    u_dn.ready = 1'b1;
    step();
    check("s2_second", W'(u_dn.ctrl), W'(8'h3C));
    step();
    check("s2_empty", W'(u_dn.valid), W'(0));

    // Flush from SKID with a concurrent offer.
    u_dn.ready = 1'b0;
    drive_in(1'b1, 8'h11); step();
    drive_in(1'b1, 8'h22); step();
    flush = 1'b1;
    drive_in(1'b1, 8'h33); step();
    flush = 1'b0;
    drive_in(1'b0, '0);
    check("s3_out_valid", W'(u_dn.valid), W'(0));
    check("s3_out_ctrl", W'(u_dn.ctrl), W'(0));
    check("s3_in_ready", W'(u_up.ready), W'(1));
    u_dn.ready = 1'b1;
    repeat (3) step();

    // Stall counter: count, saturate on the 2-bit twin, clear beats increment.
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    u_dn.ready = 1'b0;
    drive_in(1'b1, 8'h44); step();
    drive_in(1'b0, '0);
    repeat (5) step();
    check("s4_stall5", W'(stall_cnt), W'(5));
    step();
    check("s4_stall6", W'(stall_cnt), W'(6));
    check("s4_sat2", W'(stall_cnt2), W'(3));
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    check("s4_clr", W'(stall_cnt), W'(0));
    check("s4_clr2", W'(stall_cnt2), W'(0));

    // Reset while in SKID, then resume.
    drive_in(1'b1, 8'h55); step();
    drive_in(1'b0, '0);
    check("s5_in_skid", W'(u_up.ready), W'(0));
    rst = 1'b1; step(); rst = 1'b0;
    check("s5_out_valid", W'(u_dn.valid), W'(0));
    check("s5_out_ctrl", W'(u_dn.ctrl), W'(0));
    check("s5_in_ready", W'(u_up.ready), W'(1));
    check("s5_stall", W'(stall_cnt), W'(0));
    u_dn.ready = 1'b1;
    drive_in(1'b1, 8'h66); step();
    drive_in(1'b0, '0);
    check("s5_resume", W'(u_dn.ctrl), W'(8'h66));
    step();

    // Random traffic; an unaccepted offer is held unchanged by upstream.
    for (int i = 0; i < 10000; i++) begin
      if (!(u_up.valid && !last_acc)) drive_in(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom()));
      u_dn.ready = 1'($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 63) == 0);
      clr_cnt    = ($urandom_range(0, 127) == 0);
      step();
    end
    flush = 1'b0; clr_cnt = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
